// File: rtl/hazard_stall_if.sv
// Pipeline-register fields consumed by the hazard/stall controller and the
// freeze/flush/bubble controls it returns to the pipeline registers.
interface hazard_stall_if;
    logic       fwd_en;
    logic [4:0] id_src1;
    logic [4:0] id_src2;
    logic       id_two_src;
    logic [4:0] exe_dst;
    logic       exe_wb_en;
    logic       exe_mem_r_en;
    logic [4:0] mem_dst;
    logic       mem_wb_en;
    logic       br_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_freeze;
    logic       ifid_freeze;
    logic       ifid_flush;
    logic       idex_freeze;
    logic       idex_bubble;
    logic       exmem_freeze;
    logic       memwb_bubble;

    // Handshake: mem_req is held by the MEM stage until a cycle with mem_ready=1
    // completes the access; mem_req&&mem_ready in the same cycle is a zero-wait access.
    modport master (
        output fwd_en, id_src1, id_src2, id_two_src, exe_dst, exe_wb_en, exe_mem_r_en,
               mem_dst, mem_wb_en, br_taken, mem_req, mem_ready,
        input  pc_freeze, ifid_freeze, ifid_flush, idex_freeze, idex_bubble,
               exmem_freeze, memwb_bubble
    );

    modport slave (
        input  fwd_en, id_src1, id_src2, id_two_src, exe_dst, exe_wb_en, exe_mem_r_en,
               mem_dst, mem_wb_en, br_taken, mem_req, mem_ready,
        output pc_freeze, ifid_freeze, ifid_flush, idex_freeze, idex_bubble,
               exmem_freeze, memwb_bubble
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use and RAW stalls, taken-branch flush,
// memory-wait stalls with timeout, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    hazard_stall_if.slave    pipe,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       state_dbg
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam int              WC_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]      state;
    logic [WC_W-1:0] wait_cnt;

    logic m1_exe, m2_exe, m1_mem, m2_mem;
    logic dhaz, mstall;
    logic pc_freeze, ifid_freeze, ifid_flush, idex_freeze;
    logic idex_bubble, exmem_freeze, memwb_bubble;

    assign m1_exe = pipe.exe_wb_en && (pipe.exe_dst == pipe.id_src1) && (pipe.id_src1 != 5'd0);
    assign m2_exe = pipe.id_two_src && pipe.exe_wb_en &&
                    (pipe.exe_dst == pipe.id_src2) && (pipe.id_src2 != 5'd0);
    assign m1_mem = pipe.mem_wb_en && (pipe.mem_dst == pipe.id_src1) && (pipe.id_src1 != 5'd0);
    assign m2_mem = pipe.id_two_src && pipe.mem_wb_en &&
                    (pipe.mem_dst == pipe.id_src2) && (pipe.id_src2 != 5'd0);

    // With forwarding, only a load in EXE cannot be bypassed in time.
    assign dhaz   = pipe.fwd_en ? (pipe.exe_mem_r_en && (m1_exe || m2_exe))
                                : (m1_exe || m2_exe || m1_mem || m2_mem);
    assign mstall = pipe.mem_req && !pipe.mem_ready;

    always_comb begin
        pc_freeze    = 1'b0;
        ifid_freeze  = 1'b0;
        ifid_flush   = 1'b0;
        idex_freeze  = 1'b0;
        idex_bubble  = 1'b0;
        exmem_freeze = 1'b0;
        memwb_bubble = 1'b0;
        // Outputs are forced quiet while reset is asserted, not just after the edge.
        if (rst) begin
            pc_freeze = 1'b0;
        end else if (state == ST_ERR || mstall) begin
            pc_freeze    = 1'b1;
            ifid_freeze  = 1'b1;
            idex_freeze  = 1'b1;
            exmem_freeze = 1'b1;
            memwb_bubble = 1'b1;
        end else if (pipe.br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (dhaz) begin
            pc_freeze   = 1'b1;
            ifid_freeze = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    assign pipe.pc_freeze    = pc_freeze;
    assign pipe.ifid_freeze  = ifid_freeze;
    assign pipe.ifid_flush   = ifid_flush;
    assign pipe.idex_freeze  = idex_freeze;
    assign pipe.idex_bubble  = idex_bubble;
    assign pipe.exmem_freeze = exmem_freeze;
    assign pipe.memwb_bubble = memwb_bubble;
    assign state_dbg         = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mstall) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                ST_WAIT: begin
                    // A withdrawn request ends the wait just like a completed one.
                    if (pipe.mem_ready || !pipe.mem_req) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WC_LAST) begin
                        state   <= ST_ERR;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                ST_ERR: state <= ST_ERR;
                default: begin
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (pc_freeze && stall_cycles != CNT_MAX) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
endmodule
